// File: rtl/mips_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Optional feature: define ADDI_EN to make opcode 001000 (addi) legal.
module mips_main_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] instr_cnt_r;
  logic             retire_s;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       i_or_d_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       mem_to_reg_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_src_s;
  logic       illegal_op_s;

  // The branch decision (pc_write_cond & zero) is formed in the datapath, not here.
  logic unused_zero_s;
  assign unused_zero_s = zero;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef ADDI_EN
      OP_ADDI:                          op_legal = 1'b1;
`endif
      default:                          op_legal = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_s = S_DECODE;
        else           next_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_R:         next_s = S_EXEC;
          OP_BEQ:       next_s = S_BRANCH;
          OP_J:         next_s = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      next_s = S_ADDIEX;
`endif
          default:      next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW)      next_s = S_MEMWR;
        else if (opcode == OP_LW) next_s = S_MEMRD;
        else                      next_s = S_FETCH;
      end
      S_MEMRD: begin
        if (mem_ready) next_s = S_MEMWB;
        else           next_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) next_s = S_FETCH;
        else           next_s = S_MEMWR;
      end
      S_EXEC:   next_s = S_ALUWB;
`ifdef ADDI_EN
      S_ADDIEX: next_s = S_ADDIWB;
`endif
      default:  next_s = S_FETCH;
    endcase
  end

  // Moore output decode (FETCH ir_write/pc_write follow mem_ready)
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    pc_src_s        = 2'b00;
    illegal_op_s    = 1'b0;
    retire_s        = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b_s  = 2'b11;
        illegal_op_s = ~op_legal(opcode);
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        retire_s    = mem_ready;
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        retire_s    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_src_s        = 2'b01;
        retire_s        = 1'b1;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_s   = 2'b10;
        retire_s   = 1'b1;
      end
`ifdef ADDI_EN
      S_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
`endif
      default: begin
        retire_s = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_r <= '0;
    end else if (retire_s) begin
      instr_cnt_r <= instr_cnt_r + CNT_W'(1);
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  // The state register resets to FETCH, so outputs are masked directly while reset is held.
  assign pc_write      = pc_write_s      & rst_n;
  assign pc_write_cond = pc_write_cond_s & rst_n;
  assign i_or_d        = i_or_d_s        & rst_n;
  assign mem_read      = mem_read_s      & rst_n;
  assign mem_write     = mem_write_s     & rst_n;
  assign ir_write      = ir_write_s      & rst_n;
  assign mem_to_reg    = mem_to_reg_s    & rst_n;
  assign reg_dst       = reg_dst_s       & rst_n;
  assign reg_write     = reg_write_s     & rst_n;
  assign alu_src_a     = alu_src_a_s     & rst_n;
  assign alu_src_b     = alu_src_b_s     & {2{rst_n}};
  assign alu_op        = alu_op_s        & {2{rst_n}};
  assign pc_src        = pc_src_s        & {2{rst_n}};
  assign illegal_op    = illegal_op_s    & rst_n;
  assign instr_cnt     = instr_cnt_r;

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Randomized bench for mips_main_ctrl: expected per-cycle control vectors are built from per-instruction step lists.
module tb_mips_main_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] instr_cnt;

  mips_main_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  typedef struct {
    logic [16:0] exp;
    logic        rdy;
    logic [5:0]  op;
    logic        inc;
  } cyc_t;

  cyc_t       q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] model_cnt = 4'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Control vector: pw pwc iod mr mw irw m2r rd rw asa asb aop psrc ill
  function automatic logic [16:0] v(input logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa,
                                    input logic [1:0] asb, aop, psrc, input logic ill);
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  // 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 addi, -1 illegal
  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
`ifdef ADDI_EN
      6'b001000: return 5;
`endif
      default:   return -1;
    endcase
  endfunction

  task automatic add(input logic [16:0] e, input logic r, input logic [5:0] op, input logic inc);
    cyc_t c;
    c.exp = e; c.rdy = r; c.op = op; c.inc = inc;
    q.push_back(c);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_instr(input logic [5:0] op, input int fs, input int ms);
    int k;
    k = kind_of(op);
    for (int i = 0; i < fs; i++)
      add(v(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0), 1'b0, op, 1'b0);
    add(v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0), 1'b1, op, 1'b0);
    add(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,(k < 0)), rnd(), op, 1'b0);
    case (k)
      0: begin
        add(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0), rnd(), op, 1'b0);
        add(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0), rnd(), op, 1'b1);
      end
      1, 2: begin
        add(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0), rnd(), op, 1'b0);
        for (int i = 0; i <= ms; i++)
          add(v(1'b0,1'b0,1'b1,(k == 1),(k == 2),1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0),
              (i == ms), op, (k == 2) && (i == ms));
        if (k == 1)
          add(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0), rnd(), op, 1'b1);
      end
      3: add(v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0), rnd(), op, 1'b1);
      4: add(v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0), rnd(), op, 1'b1);
      5: begin
        add(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0), rnd(), op, 1'b0);
        add(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0), rnd(), op, 1'b1);
      end
      default: ;
    endcase
  endtask

  // Called just after a rising edge; consumes n queued cycles.
  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      opcode    = c.op;
      zero      = rnd();
      @(negedge clk);
      check_val("ctrl", 32'(obs), 32'(c.exp));
      check_val("cnt", 32'(instr_cnt), 32'(model_cnt));
      @(posedge clk);
      #1;
      if (c.inc) model_cnt = model_cnt + 4'd1;
    end
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  task automatic reset_and_release();
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    #1;
    check_val("post_rst_ctrl", 32'(obs),
              32'(v(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0)));
    check_val("post_rst_cnt", 32'(instr_cnt), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] op;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    #2;
    check_val("rst_ctrl", 32'(obs), 32'd0);
    check_val("rst_cnt", 32'(instr_cnt), 32'd0);
    reset_and_release();

    // Directed: R-type, lw with 3-cycle memory stall, beq, illegal, addi/illegal per build
    push_instr(6'b000000, 0, 0); run_all();
    push_instr(6'b100011, 0, 3); run_all();
    push_instr(6'b000100, 0, 0); run_all();
    push_instr(6'b111111, 0, 0); run_all();
    push_instr(6'b001000, 0, 0); run_all();
    push_instr(6'b101011, 2, 2); run_all();

    // Reset asserted in the middle of EXEC
    push_instr(6'b000000, 0, 0);
    run_n(2);
    q.delete();
    mem_ready = 1'b1;
    #3;
    check_val("exec_ctrl", 32'(obs),
              32'(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0)));
    rst_n = 1'b0;
    #1;
    check_val("midrst_ctrl", 32'(obs), 32'd0);
    check_val("midrst_cnt", 32'(instr_cnt), 32'd0);
    model_cnt = 4'd0;
    reset_and_release();

    // Counter wrap: 16 jumps bring the 4-bit count back to its start
    for (int i = 0; i < 15; i++) push_instr(6'b000010, 0, 0);
    run_all();
    check_val("cnt_15", 32'(instr_cnt), 32'd15);
    push_instr(6'b000010, 0, 0); run_all();
    check_val("cnt_wrap", 32'(instr_cnt), 32'd0);

    // Randomized instruction mix with random memory stalls
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom_range(0, 63));
      endcase
      push_instr(op, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      run_all();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
